// File: rtl/fp16_pkg.sv
// fp16_pkg: fp16/int16 encoding constants shared by the converter and the
// arbitrated conversion front-end.
package fp16_pkg;
    localparam logic [4:0]  FP16_EXP_MAX   = 5'd31;
    localparam logic [4:0]  FP16_SAT_EXP   = 5'd30;
    localparam logic [4:0]  FP16_BIAS      = 5'd15;
    localparam logic [4:0]  FP16_MAN_W     = 5'd10;
    localparam logic [15:0] INT16_MAX      = 16'h7FFF;
    localparam logic [15:0] INT16_MIN      = 16'h8000;
    localparam logic [15:0] FP16_NEG_32768 = 16'hF800;
endpackage

// File: rtl/fp16_to_int16.sv
// fp16_to_int16: combinational fp16 -> int16 conversion, truncating toward
// zero. Out-of-range values and Inf clamp to INT16_MAX/INT16_MIN, NaN gives 0;
// all of those raise sat. -32768 is the only exp==30 value that fits exactly.
module fp16_to_int16
    import fp16_pkg::*;
(
    input  logic [15:0] fp_in,
    output logic [15:0] int_out,
    output logic        sat
);
    logic        sign;
    logic [4:0]  exp_f;
    logic [15:0] man;
    logic [15:0] mag;

    assign sign  = fp_in[15];
    assign exp_f = fp_in[14:10];
    assign man   = {5'b0, 1'b1, fp_in[9:0]};

    // Classify by exponent, then shift the 11-bit significand into place.
    always_comb begin
        mag     = '0;
        int_out = '0;
        sat     = 1'b0;
        if (exp_f == FP16_EXP_MAX) begin
            sat     = 1'b1;
            int_out = (fp_in[9:0] != 10'd0) ? 16'd0 : (sign ? INT16_MIN : INT16_MAX);
        end else if (exp_f == FP16_SAT_EXP) begin
            if (fp_in == FP16_NEG_32768) begin
                int_out = INT16_MIN;
            end else begin
                sat     = 1'b1;
                int_out = sign ? INT16_MIN : INT16_MAX;
            end
        end else if (exp_f >= FP16_BIAS) begin
            // Binary point sits FP16_BIAS+FP16_MAN_W (=25) exponent steps up.
            if (exp_f >= FP16_BIAS + FP16_MAN_W)
                mag = man << (exp_f - (FP16_BIAS + FP16_MAN_W));
            else
                mag = man >> ((FP16_BIAS + FP16_MAN_W) - exp_f);
            int_out = sign ? (~mag + 16'd1) : mag;
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter. Searches upward from ptr with wrap, grants
// one requester when enabled, and advances ptr past the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_vld
);
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    cand;
    logic [NUM_REQ-1:0] req_sh;
    logic               found;
    int                 j;

    // First requester at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        req_sh  = '0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            cand   = ID_W'(j);
            req_sh = req >> cand;
            if (!found && req_sh[0]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_vld = en & found;
        gnt     = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    // Pointer moves just past the winner; holds when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld)
            ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/fp16_to_int16_arb.sv
// fp16_to_int16_arb: NUM_REQ fp16 streams share one converter through a
// round-robin arbiter; results leave on one registered valid/ready stream
// tagged with the requester id. Keeps per-requester sticky saturation flags.
// Optional FP16_TO_INT16_ARB_SATCNT_EN adds a saturating 16-bit count of
// accepted saturating operands (sat_count).
module fp16_to_int16_arb
    import fp16_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_data,
    output logic [ID_W-1:0]       out_id,
    output logic                  out_sat,
    output logic [NUM_REQ-1:0]    sat_sticky,
    input  logic [NUM_REQ-1:0]    sat_clr
`ifdef FP16_TO_INT16_ARB_SATCNT_EN
    ,
    output logic [15:0]           sat_count
`endif
);
    logic               accept;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_vld;
    logic [15:0]        sel_fp;
    logic [15:0]        conv_int;
    logic               conv_sat;

    logic               out_valid_q, out_valid_d;
    logic [15:0]        out_data_q, out_data_d;
    logic [ID_W-1:0]    out_id_q, out_id_d;
    logic               out_sat_q, out_sat_d;
    logic [NUM_REQ-1:0] sat_sticky_q, sat_sticky_d;

    // Output slot is free when empty or draining this cycle; never grant in reset.
    assign accept = out_ready | ~out_valid_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .en      (accept & rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign req_ready = gnt;
    assign sel_fp    = 16'(req_data >> {gnt_idx, 4'b0});

    fp16_to_int16 u_conv (
        .fp_in   (sel_fp),
        .int_out (conv_int),
        .sat     (conv_sat)
    );

    // Output register: load on transfer, drop valid on drain, hold on stall.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_sat_d   = out_sat_q;
        if (gnt_vld) begin
            out_valid_d = 1'b1;
            out_data_d  = conv_int;
            out_id_d    = gnt_idx;
            out_sat_d   = conv_sat;
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    // Sticky flags: set beats clear when both hit the same requester.
    always_comb begin
        sat_sticky_d = (sat_sticky_q & ~sat_clr) | (gnt & {NUM_REQ{conv_sat}});
    end

    // Output and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_id_q     <= '0;
            out_sat_q    <= 1'b0;
            sat_sticky_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
            out_sat_q    <= out_sat_d;
            sat_sticky_q <= sat_sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_id     = out_id_q;
    assign out_sat    = out_sat_q;
    assign sat_sticky = sat_sticky_q;

`ifdef FP16_TO_INT16_ARB_SATCNT_EN
    logic [15:0] sat_count_q, sat_count_d;
    logic        cnt_inc;
    logic        cnt_clr;

    assign cnt_inc = gnt_vld & conv_sat;
    assign cnt_clr = &sat_clr;

    // Saturating counter; a coinciding clear restarts the count at 1.
    always_comb begin
        sat_count_d = sat_count_q;
        if (cnt_inc) begin
            if (cnt_clr)                    sat_count_d = 16'd1;
            else if (sat_count_q != 16'hFFFF) sat_count_d = sat_count_q + 16'd1;
        end else if (cnt_clr) begin
            sat_count_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_count_q <= '0;
        else        sat_count_q <= sat_count_d;
    end

    assign sat_count = sat_count_q;
`else
    // Counter not built: only the sticky flags report saturation.
`endif
endmodule

// File: tb/tb_fp16_to_int16_arb.sv
// tb_fp16_to_int16_arb: directed vectors for the shared fp16->int16 arbiter.
module tb_fp16_to_int16_arb;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           out_data;
    logic [ID_W-1:0]       out_id;
    logic                  out_sat;
    logic [NUM_REQ-1:0]    sat_sticky;
    logic [NUM_REQ-1:0]    sat_clr;
`ifdef FP16_TO_INT16_ARB_SATCNT_EN
    logic [15:0]           sat_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fp16_to_int16_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_sat    (out_sat),
        .sat_sticky (sat_sticky),
        .sat_clr    (sat_clr)
`ifdef FP16_TO_INT16_ARB_SATCNT_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] fp;
        logic [15:0] exp_int;
        logic        exp_sat;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{0, 16'h4248, 16'h0003, 1'b0}; // 3.14
        tbl[1]  = '{1, 16'h3C00, 16'h0001, 1'b0}; // 1.0
        tbl[2]  = '{2, 16'hBC00, 16'hFFFF, 1'b0}; // -1.0
        tbl[3]  = '{3, 16'h3800, 16'h0000, 1'b0}; // 0.5
        tbl[4]  = '{0, 16'h0000, 16'h0000, 1'b0}; // +0
        tbl[5]  = '{1, 16'hC248, 16'hFFFD, 1'b0}; // -3.14
        tbl[6]  = '{2, 16'h7BFF, 16'h7FFF, 1'b1}; // 65504
        tbl[7]  = '{2, 16'h7C00, 16'h7FFF, 1'b1}; // +Inf
        tbl[8]  = '{3, 16'hFC00, 16'h8000, 1'b1}; // -Inf
        tbl[9]  = '{2, 16'hF800, 16'h8000, 1'b0}; // -32768 exact
        tbl[10] = '{1, 16'hF801, 16'h8000, 1'b1}; // just below -32768
        tbl[11] = '{2, 16'h7E00, 16'h0000, 1'b1}; // NaN
        tbl[12] = '{0, 16'h77FF, 16'h7FF0, 1'b0}; // 32752
        tbl[13] = '{3, 16'hF7FF, 16'h8010, 1'b0}; // -32752
        tbl[14] = '{1, 16'h5640, 16'h0064, 1'b0}; // 100.0
        tbl[15] = '{3, 16'h0001, 16'h0000, 1'b0}; // subnormal

        // Reset state, with requests already pending.
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = {16'h4400, 16'h4200, 16'h4000, 16'h3C00}; // 4,3,2,1
        out_ready = 1'b1;
        sat_clr   = '0;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_sticky", 32'(sat_sticky), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Round-robin with all valid: 0,1,2,3,0,... back to back.
        for (int k = 0; k < 8; k++) begin
            chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            step();
            chk("rr_valid", 32'(out_valid), 32'h1);
            chk("rr_id", 32'(out_id), 32'(k % 4));
            chk("rr_data", 32'(out_data), 32'((k % 4) + 1));
        end

        // Backpressure: result from requester 3 must hold, no grants.
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready", 32'(req_ready), 32'h0);
            step();
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_id", 32'(out_id), 32'h3);
            chk("bp_data", 32'(out_data), 32'h4);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_ready", 32'(req_ready), 32'h1);
        step();
        chk("bp_rel_id", 32'(out_id), 32'h0);
        chk("bp_rel_data", 32'(out_data), 32'h1);

        // Conversion table, one requester at a time; sticky cleared before each.
        for (int i = 0; i < 16; i++) begin
            req_valid = '0;
            sat_clr   = '1;
            step();
            chk("tbl_drain", 32'(out_valid), 32'h0);
            sat_clr   = '0;
            req_data  = '0;
            req_data[tbl[i].id*16 +: 16] = tbl[i].fp;
            req_valid = NUM_REQ'(1) << tbl[i].id;
            #1;
            chk("tbl_ready", 32'(req_ready), 32'(1 << tbl[i].id));
            step();
            chk("tbl_valid", 32'(out_valid), 32'h1);
            chk("tbl_data", 32'(out_data), 32'(tbl[i].exp_int));
            chk("tbl_id", 32'(out_id), 32'(tbl[i].id));
            chk("tbl_sat", 32'(out_sat), 32'(tbl[i].exp_sat));
            chk("tbl_sticky", 32'(sat_sticky), 32'(tbl[i].exp_sat) << tbl[i].id);
        end

        // Sticky: set, set+clear (set wins), clear alone.
        req_valid = '0;
        sat_clr   = '1;
        step();
        sat_clr   = '0;
        req_data  = '0;
        req_data[2*16 +: 16] = 16'h7C00;
        req_valid = 4'b0100;
        step();
        chk("stk_set", 32'(sat_sticky), 32'h4);
        sat_clr = 4'b0100;
        step();
        chk("stk_set_wins", 32'(sat_sticky), 32'h4);
        req_valid = '0;
        step();
        chk("stk_clr", 32'(sat_sticky), 32'h0);
        sat_clr = '0;

        // Reset mid-stream.
        req_data  = {16'h3C00, 16'h3C00, 16'h7C00, 16'h3C00};
        req_valid = '1;
        for (int k = 0; k < 4; k++) step();
        chk("mid_pre_valid", 32'(out_valid), 32'h1);
        chk("mid_pre_sticky", 32'(sat_sticky), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 32'h0);
        chk("mid_sticky", 32'(sat_sticky), 32'h0);
        chk("mid_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_ptr0", 32'(req_ready), 32'h1);
        step();
        chk("mid_id0", 32'(out_id), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
